// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed driver for an 8-digit, common-anode, 7-segment display.
//
// Two-state scanner. In BLANK every anode is off for exactly BLANK_CYC cycles.
// It then enters SHOW and drives one digit until the next refresh tick.
// On SHOW entry the digit's nibble, decimal point, blank and blink bits and the
// blink phase are captured. The outputs stay fixed until the next tick.
// All outputs come straight from flops.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   tick        refresh strobe; advances to the next digit (ignored in BLANK)
//   digits      eight hex nibbles, digit k in [4k+3:4k]
//   dp_en       per-digit decimal point request, active-high
//   blank_mask  per-digit force-off, active-high
//   blink_mask  per-digit blink enable, active-high
//   blink_tick  toggles the blink phase
//   an          anode enables, active-low
//   seg         cathodes {g,f,e,d,c,b,a}, active-low
//   dp          decimal-point cathode, active-low
//   digit_idx   digit being shown, or the one about to be shown
module seg_scan #(
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_en,
  input  logic [7:0]  blank_mask,
  input  logic [7:0]  blink_mask,
  input  logic        blink_tick,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  digit_idx
);

  typedef enum logic [0:0] {StShow, StBlank} state_e;

  localparam logic [7:0] CntLast = 8'(BLANK_CYC - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [2:0] idx_q;
  logic       phase_q;
  logic [7:0] an_q;
  logic [6:0] seg_q;
  logic       dp_q;

  logic [3:0] nibble;
  logic [6:0] seg_dec;
  logic       digit_off;
  logic [7:0] an_sel;

  assign nibble    = digits[{idx_q, 2'b00} +: 4];
  // Masked or in the "off" half of a blink: keep anodes off but still decode seg.
  assign digit_off = blank_mask[idx_q] | (blink_mask[idx_q] & phase_q);
  assign an_sel    = 8'hFF ^ (8'h01 << idx_q);

  always_comb begin
    seg_dec = 7'h7F;
    unique case (nibble)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBlank;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      phase_q <= 1'b0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      // Phase runs in any state; it is only sampled on SHOW entry.
      if (blink_tick) phase_q <= ~phase_q;
      unique case (state_q)
        StShow: begin
          if (tick) begin
            state_q <= StBlank;
            idx_q   <= idx_q + 3'd1;
            cnt_q   <= 8'd0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
          end
        end
        StBlank: begin
          if (cnt_q == CntLast) begin
            state_q <= StShow;
            cnt_q   <= 8'd0;
            an_q    <= digit_off ? 8'hFF : an_sel;
            seg_q   <= seg_dec;
            dp_q    <= ~dp_en[idx_q];
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StBlank;
      endcase
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;

endmodule
